// File: rtl/router_fsm.sv
// Packet router control FSM: tracks header decode, payload load,
// FIFO-full stalls and parity check for one packet at a time.
module router_fsm (
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic       fifo_full,
  input  logic [1:0] data_in,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  output logic       busy,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       write_enb_reg,
  output logic       full_state,
  output logic       laf_state,
  output logic       rst_int_reg
);

  typedef enum logic [2:0] {
    DA  = 3'd0,
    LFD = 3'd1,
    LD  = 3'd2,
    LP  = 3'd3,
    FFS = 3'd4,
    LAF = 3'd5,
    CPE = 3'd6
  } state_t;

  state_t     state;
  state_t     nxt;
  logic [1:0] addr;
  logic       soft_hit;
  logic       take_hdr;

  assign take_hdr = (state == DA) && pkt_valid && (data_in != 2'd3);

  // only the FIFO owning the active packet may abort it
  always_comb begin
    soft_hit = 1'b0;
    unique case (addr)
      2'd0:    soft_hit = soft_reset_0;
      2'd1:    soft_hit = soft_reset_1;
      2'd2:    soft_hit = soft_reset_2;
      default: soft_hit = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (resetn) begin
      state <= DA;
      addr  <= 2'd0;
    end else begin
      state <= nxt;
      if (take_hdr)
        addr <= data_in;
    end
  end

  always_comb begin
    nxt = state;
    if (state != DA && soft_hit) begin
      nxt = DA;
    end else begin
      unique case (state)
        DA:      nxt = take_hdr ? LFD : DA;
        LFD:     nxt = LD;
        LD: begin
          if (fifo_full)
            nxt = FFS;
          else if (!pkt_valid)
            nxt = LP;
          else
            nxt = LD;
        end
        FFS:     nxt = fifo_full ? FFS : LAF;
        LAF: begin
          if (parity_done)
            nxt = DA;
          else if (low_pkt_valid)
            nxt = LP;
          else
            nxt = LD;
        end
        LP:      nxt = CPE;
        CPE:     nxt = fifo_full ? FFS : DA;
        default: nxt = DA;
      endcase
    end
  end

  always_comb begin
    detect_add    = (state == DA);
    lfd_state     = (state == LFD);
    ld_state      = (state == LD);
    full_state    = (state == FFS);
    laf_state     = (state == LAF);
    rst_int_reg   = (state == CPE);
    write_enb_reg = (state == LD) || (state == LP) || (state == LAF);
    busy          = (state == LFD) || (state == LP) || (state == FFS)
                 || (state == LAF) || (state == CPE);
  end

endmodule

// File: tb/tb_router_fsm.sv
// Directed bench for router_fsm with a per-cycle reference model
// and literal output checks at key points of each scenario.
module tb_router_fsm;

  logic       clock = 1'b0;
  logic       resetn = 1'b1;
  logic       pkt_valid = 1'b0;
  logic       fifo_full = 1'b0;
  logic [1:0] data_in = 2'd0;
  logic       parity_done = 1'b0;
  logic       low_pkt_valid = 1'b0;
  logic       soft_reset_0 = 1'b0;
  logic       soft_reset_1 = 1'b0;
  logic       soft_reset_2 = 1'b0;
  logic       busy, detect_add, lfd_state, ld_state;
  logic       write_enb_reg, full_state, laf_state, rst_int_reg;

  int total = 0;
  int bad   = 0;

  router_fsm dut (
    .clock         (clock),
    .resetn        (resetn),
    .pkt_valid     (pkt_valid),
    .fifo_full     (fifo_full),
    .data_in       (data_in),
    .parity_done   (parity_done),
    .low_pkt_valid (low_pkt_valid),
    .soft_reset_0  (soft_reset_0),
    .soft_reset_1  (soft_reset_1),
    .soft_reset_2  (soft_reset_2),
    .busy          (busy),
    .detect_add    (detect_add),
    .lfd_state     (lfd_state),
    .ld_state      (ld_state),
    .write_enb_reg (write_enb_reg),
    .full_state    (full_state),
    .laf_state     (laf_state),
    .rst_int_reg   (rst_int_reg)
  );

  always #5 clock = ~clock;

  logic [7:0] dut_vec;
  assign dut_vec = {busy, detect_add, lfd_state, ld_state,
                    write_enb_reg, full_state, laf_state, rst_int_reg};

  // output vector order: busy detect lfd ld wen full laf rst_int
  localparam logic [7:0] O_DA  = 8'b0100_0000;
  localparam logic [7:0] O_LFD = 8'b1010_0000;
  localparam logic [7:0] O_LD  = 8'b0001_1000;
  localparam logic [7:0] O_LP  = 8'b1000_1000;
  localparam logic [7:0] O_FFS = 8'b1000_0100;
  localparam logic [7:0] O_LAF = 8'b1000_1010;
  localparam logic [7:0] O_CPE = 8'b1000_0001;

  typedef enum int {M_DA, M_LFD, M_LD, M_LP, M_FFS, M_LAF, M_CPE} mst_t;

  mst_t       m_st = M_DA;
  int         m_addr = 0;
  bit         mdl_ok = 1'b0;
  logic [2:0] srv;

  assign srv = {soft_reset_2, soft_reset_1, soft_reset_0};

  function automatic logic [7:0] m_out(input mst_t s);
    logic [7:0] tbl [7];
    tbl = '{O_DA, O_LFD, O_LD, O_LP, O_FFS, O_LAF, O_CPE};
    return tbl[int'(s)];
  endfunction

  task automatic chk(input string nm, input logic [7:0] got,
                     input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %b want %b", nm, $time, got, exp);
    end
  endtask

  always @(posedge clock) begin
    if (resetn) begin
      m_st   = M_DA;
      m_addr = 0;
      mdl_ok = 1'b1;
    end else if (m_st != M_DA && srv[m_addr]) begin
      m_st = M_DA;
    end else begin
      case (m_st)
        M_DA:
          if (pkt_valid && data_in != 2'd3) begin
            m_st   = M_LFD;
            m_addr = int'(data_in);
          end
        M_LFD: m_st = M_LD;
        M_LD:
          if (fifo_full) m_st = M_FFS;
          else if (!pkt_valid) m_st = M_LP;
        M_FFS: if (!fifo_full) m_st = M_LAF;
        M_LAF:
          if (parity_done) m_st = M_DA;
          else if (low_pkt_valid) m_st = M_LP;
          else m_st = M_LD;
        M_LP:  m_st = M_CPE;
        M_CPE: m_st = fifo_full ? M_FFS : M_DA;
        default: m_st = M_DA;
      endcase
    end
  end

  always @(negedge clock)
    if (mdl_ok)
      chk("model", dut_vec, m_out(m_st));

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    fork
      begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
      end
    join_none

    tick();
    chk("reset", dut_vec, O_DA);
    resetn = 0;

    pkt_valid = 1; data_in = 2'd1;
    tick(); chk("p1_lfd", dut_vec, O_LFD);
    tick(); chk("p1_ld", dut_vec, O_LD);
    pkt_valid = 0;
    tick(); chk("p1_lp", dut_vec, O_LP);
    tick(); chk("p1_cpe", dut_vec, O_CPE);
    tick(); chk("p1_da", dut_vec, O_DA);

    pkt_valid = 1; data_in = 2'd0;
    tick(); tick();
    fifo_full = 1;
    tick(); chk("ffs", dut_vec, O_FFS);
    tick(); chk("ffs_hold", dut_vec, O_FFS);
    fifo_full = 0;
    tick(); chk("laf", dut_vec, O_LAF);
    low_pkt_valid = 1;
    tick(); chk("laf_lp", dut_vec, O_LP);
    low_pkt_valid = 0; pkt_valid = 0;
    tick(); tick(); chk("p2_da", dut_vec, O_DA);

    pkt_valid = 1;
    tick(); tick();
    fifo_full = 1; tick();
    fifo_full = 0; tick();
    parity_done = 1;
    tick(); chk("laf_pd_da", dut_vec, O_DA);
    parity_done = 0;
    tick(); tick();
    fifo_full = 1; tick();
    fifo_full = 0; tick(); chk("laf2", dut_vec, O_LAF);
    tick(); chk("laf_ld", dut_vec, O_LD);
    pkt_valid = 0;
    tick(); tick(); tick(); chk("p3_da", dut_vec, O_DA);

    pkt_valid = 1; data_in = 2'd3;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("bad_addr", dut_vec, O_DA);
    end

    data_in = 2'd2;
    tick(); chk("a2_lfd", dut_vec, O_LFD);
    data_in = 2'd0;
    tick();
    soft_reset_0 = 1;
    tick(); chk("sr0_ign", dut_vec, O_LD);
    soft_reset_1 = 1;
    tick(); chk("sr1_ign", dut_vec, O_LD);
    soft_reset_0 = 0; soft_reset_1 = 0; soft_reset_2 = 1;
    tick(); chk("sr2_da", dut_vec, O_DA);
    soft_reset_2 = 0;

    soft_reset_0 = 1;
    tick(); chk("sr_in_da", dut_vec, O_LFD);
    tick(); chk("sr_lfd", dut_vec, O_DA);
    soft_reset_0 = 0;

    data_in = 2'd1;
    tick(); tick();
    pkt_valid = 0;
    tick(); fifo_full = 1;
    tick(); chk("cpe", dut_vec, O_CPE);
    tick(); chk("cpe_ffs", dut_vec, O_FFS);
    resetn = 1;
    tick(); chk("ffs_rst", dut_vec, O_DA);
    resetn = 0; fifo_full = 0;

    pkt_valid = 1; data_in = 2'd2;
    tick(); chk("lfd_b", dut_vec, O_LFD);
    resetn = 1; soft_reset_2 = 1;
    tick(); chk("lfd_rst", dut_vec, O_DA);
    soft_reset_2 = 0; data_in = 2'd1;
    tick(); chk("rst_hold", dut_vec, O_DA);
    resetn = 0; pkt_valid = 0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
